alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width (>=4).
REQ-002 Parameter ADDR_W, default 8, destination register address width.
REQ-003 Reset Reset, asynchronous, active-high; clock Clock.
REQ-004 Clock  in  1  system clock, all state on rising edge.
REQ-005 Reset  in  1  asynchronous active-high reset.
REQ-006 iValid  in  1  operation offered on iOp/iDst/iA/iB.
REQ-007 oReady  out  1  unit accepts operation this cycle.
REQ-008 iOp  in  4  opcode.
REQ-009 iDst  in  ADDR_W  destination register.
REQ-010 iA, iB  in  DATA_W each  operands (iA = source1, iB = source0).
REQ-011 oValid  out  1  result available.
REQ-012 iReady  in  1  consumer takes result (stall input, e.g. LCD busy).
REQ-013 oResult, oRem  out  DATA_W each  result; remainder (DIV only, else 0).
REQ-014 oDst  out  ADDR_W  captured iDst.
REQ-015 oWriteEnable, oBranch  out  1 each  register write requested; branch taken.
REQ-016 oZero, oCarry, oOverflow, oDivZero  out  1 each  status flags.

Function
REQ-017 Operation is accepted on a rising edge where iValid & oReady; operands, opcode and iDst are captured then.
REQ-018 FSM states: IDLE, BUSY, DONE; oReady = 1 in IDLE, or in DONE when iReady = 1.
REQ-019 Single-cycle ops (NOP, ADD, SUB, AND, OR, XOR, SHL, SHR, SLT, BLE): IDLE/DONE -> DONE; oValid asserted the cycle after acceptance.
REQ-020 MUL/DIV: -> BUSY; iterative shift-add / restoring algorithm, one bit per cycle; -> DONE exactly DATA_W cycles after acceptance; oValid the following cycle (latency DATA_W+1).
REQ-021 DONE holds all outputs stable while iReady = 0; DONE & iReady & !iValid -> IDLE; DONE & iReady & iValid -> accept new op (back-to-back, no bubble).
REQ-022 iValid in BUSY is ignored (oReady = 0); operands are not re-sampled.
REQ-023 ADD/SUB: DATA_W-bit wrap-around; oCarry = carry-out (ADD) or borrow (SUB, iA < iB unsigned); oOverflow = signed two's-complement overflow.
REQ-024 MUL: oResult = low DATA_W bits of unsigned iA*iB; oCarry = 1 when high half is non-zero.
REQ-025 DIV: unsigned iA/iB, remainder on oRem; iB = 0 -> oResult all ones, oRem = iA, oDivZero = 1, still DATA_W+1 latency.
REQ-026 SHL/SHR: logical shift of iA by iB[log2(DATA_W)-1:0]; larger shift amounts use those low bits only.
REQ-027 SLT: oResult = 1 if signed iA < iB, else 0.
REQ-028 BLE: oBranch = 1 when unsigned iA <= iB; oWriteEnable = 0; oResult = 0.
REQ-029 oWriteEnable = 1 for all ops except NOP and BLE; oZero = (oResult == 0) for every op.
REQ-030 Outputs other than oValid/oReady are registered and change only on an accept-completion transition.
REQ-031 Undefined opcodes behave as NOP.

Reset
REQ-032 Reset asserted -> state IDLE, oValid 0, all data outputs and flags 0, oReady 1 after release.
REQ-033 Reset during BUSY aborts the operation; no oValid is produced for it.

Structure
REQ-034 Opcode constants and FSM state encodings reside in the shared definitions package used by the MiniAlu datapath.
REQ-035 One sub-module, alu_iter_muldiv, holds the iterative MUL/DIV engine (start, op-select, done pulse).

Verification
REQ-036 DATA_W=16: ADD 0xFFFF+0x0001 -> oResult 0x0000, oZero 1, oCarry 1, oOverflow 0, oValid 1 cycle later.
REQ-037 SUB 0x8000-0x0001 -> 0x7FFF, oOverflow 1, oCarry 0.
REQ-038 MUL 0x0100*0x0100 -> oResult 0x0000, oCarry 1, oValid exactly 17 cycles after accept, oReady 0 throughout BUSY.
REQ-039 DIV 100/0 -> oResult 0xFFFF, oRem 100, oDivZero 1; DIV 100/7 -> 14, rem 2.
REQ-040 BLE 5,5 with iReady held 0 for 4 cycles -> oBranch 1, oWriteEnable 0, outputs stable, next op accepted on the cycle iReady rises.
REQ-041 Reset asserted mid-DIV (cycle 8) -> oValid 0, oReady 1 after release, no stale result.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared MiniAlu definitions: opcode encodings, execution FSM states and
// opcode classification helper.
package alu_exec_unit_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_SHR = 4'h7;
   localparam logic [3:0] OP_SLT = 4'h8;
   localparam logic [3:0] OP_BLE = 4'h9;
   localparam logic [3:0] OP_MUL = 4'hA;
   localparam logic [3:0] OP_DIV = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_iter_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_exec_unit_muldiv.sv
// Iterative unsigned MUL (shift-add) / DIV (restoring), one bit per cycle.
// done marks the cycle whose edge completes the last bit; lo_out/hi_out then
// carry the final product halves or quotient/remainder.
module alu_iter_muldiv
   import alu_exec_unit_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              start,
   input  logic              op_div,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] lo_out,
   output logic [DATA_W-1:0] hi_out
);

   localparam int CNT_W = $clog2(DATA_W);

   logic              busy;
   logic              div_mode;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] hi, lo, operand;
   logic [DATA_W-1:0] hi_next, lo_next;
   logic [DATA_W:0]   sum, shifted, diff;

   // hi:lo is the running product for MUL and the remainder:dividend pair for DIV.
   always_comb begin
      sum     = '0;
      shifted = {hi, lo[DATA_W-1]};
      diff    = shifted - {1'b0, operand};
      hi_next = hi;
      lo_next = lo;
      if (div_mode) begin
         if (!diff[DATA_W]) begin
            hi_next = diff[DATA_W-1:0];
            lo_next = {lo[DATA_W-2:0], 1'b1};
         end else begin
            hi_next = shifted[DATA_W-1:0];
            lo_next = {lo[DATA_W-2:0], 1'b0};
         end
      end else begin
         sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(DATA_W+1){1'b0}});
         hi_next = sum[DATA_W:1];
         lo_next = {sum[0], lo[DATA_W-1:1]};
      end
   end

   assign done   = busy && (count == CNT_W'(DATA_W - 1));
   assign lo_out = lo_next;
   assign hi_out = hi_next;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         busy     <= 1'b0;
         div_mode <= 1'b0;
         count    <= '0;
         hi       <= '0;
         lo       <= '0;
         operand  <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         div_mode <= op_div;
         count    <= '0;
         hi       <= '0;
         lo       <= op_div ? a : b;
         operand  <= op_div ? b : a;
      end else if (busy) begin
         hi    <= hi_next;
         lo    <= lo_next;
         count <= count + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// MiniAlu execution unit: single-cycle logic/arith ops plus iterative MUL/DIV.
// Handshake: an op is taken on a rising edge with iValid & oReady; a result is
// held while oValid & !iReady and retired on the edge where oValid & iReady.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iValid,
   output logic              oReady,
   input  logic [3:0]        iOp,
   input  logic [ADDR_W-1:0] iDst,
   input  logic [DATA_W-1:0] iA,
   input  logic [DATA_W-1:0] iB,
   output logic              oValid,
   input  logic              iReady,
   output logic [DATA_W-1:0] oResult,
   output logic [DATA_W-1:0] oRem,
   output logic [ADDR_W-1:0] oDst,
   output logic              oWriteEnable,
   output logic              oBranch,
   output logic              oZero,
   output logic              oCarry,
   output logic              oOverflow,
   output logic              oDivZero,
   output logic [1:0]        dbg_state
);

   localparam int SH_W = $clog2(DATA_W);

   state_t            state;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] dst_q;
   logic              divzero_q;
   logic              accept;
   logic              eng_done;
   logic [DATA_W-1:0] eng_lo, eng_hi;
   logic [DATA_W:0]   sum, diff;
   logic [DATA_W-1:0] r_res;
   logic              r_carry, r_ovf, r_branch, r_we;

   assign oReady    = (state == ST_IDLE) || ((state == ST_DONE) && iReady);
   assign oValid    = (state == ST_DONE);
   assign accept    = iValid && oReady;
   assign dbg_state = state;

   always_comb begin
      sum      = {1'b0, iA} + {1'b0, iB};
      diff     = {1'b0, iA} - {1'b0, iB};
      r_res    = '0;
      r_carry  = 1'b0;
      r_ovf    = 1'b0;
      r_branch = 1'b0;
      r_we     = 1'b1;
      case (iOp)
         OP_ADD: begin
            r_res   = sum[DATA_W-1:0];
            r_carry = sum[DATA_W];
            r_ovf   = (iA[DATA_W-1] == iB[DATA_W-1]) && (sum[DATA_W-1] != iA[DATA_W-1]);
         end
         OP_SUB: begin
            r_res   = diff[DATA_W-1:0];
            r_carry = diff[DATA_W];
            r_ovf   = (iA[DATA_W-1] != iB[DATA_W-1]) && (diff[DATA_W-1] != iA[DATA_W-1]);
         end
         OP_AND: r_res = iA & iB;
         OP_OR:  r_res = iA | iB;
         OP_XOR: r_res = iA ^ iB;
         OP_SHL: r_res = iA << iB[SH_W-1:0];
         OP_SHR: r_res = iA >> iB[SH_W-1:0];
         OP_SLT: r_res = {{(DATA_W-1){1'b0}}, ($signed(iA) < $signed(iB))};
         OP_BLE: begin
            r_branch = (iA <= iB);
            r_we     = 1'b0;
         end
         default: r_we = 1'b0;
      endcase
   end

   alu_iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
      .Clock  (Clock),
      .Reset  (Reset),
      .start  (accept && is_iter_op(iOp)),
      .op_div (iOp == OP_DIV),
      .a      (iA),
      .b      (iB),
      .done   (eng_done),
      .lo_out (eng_lo),
      .hi_out (eng_hi)
   );

   // Result outputs move only when an op completes; BUSY keeps the previous result.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state        <= ST_IDLE;
         op_q         <= OP_NOP;
         dst_q        <= '0;
         divzero_q    <= 1'b0;
         oResult      <= '0;
         oRem         <= '0;
         oDst         <= '0;
         oWriteEnable <= 1'b0;
         oBranch      <= 1'b0;
         oZero        <= 1'b0;
         oCarry       <= 1'b0;
         oOverflow    <= 1'b0;
         oDivZero     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  if (is_iter_op(iOp)) begin
                     state     <= ST_BUSY;
                     op_q      <= iOp;
                     dst_q     <= iDst;
                     divzero_q <= (iB == '0);
                  end else begin
                     state        <= ST_DONE;
                     oResult      <= r_res;
                     oRem         <= '0;
                     oDst         <= iDst;
                     oWriteEnable <= r_we;
                     oBranch      <= r_branch;
                     oZero        <= (r_res == '0);
                     oCarry       <= r_carry;
                     oOverflow    <= r_ovf;
                     oDivZero     <= 1'b0;
                  end
               end else if (state == ST_DONE && iReady) begin
                  state <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (eng_done) begin
                  state        <= ST_DONE;
                  oResult      <= eng_lo;
                  oRem         <= (op_q == OP_DIV) ? eng_hi : '0;
                  oDst         <= dst_q;
                  oWriteEnable <= 1'b1;
                  oBranch      <= 1'b0;
                  oZero        <= (eng_lo == '0);
                  oCarry       <= (op_q == OP_MUL) && (eng_hi != '0);
                  oOverflow    <= 1'b0;
                  oDivZero     <= (op_q == OP_DIV) && divzero_q;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with DATA_W=16, ADDR_W=8.
module tb_alu_exec_unit;
   import alu_exec_unit_pkg::*;

   logic        Clock, Reset;
   logic        iValid, oReady, iReady, oValid;
   logic [3:0]  iOp;
   logic [7:0]  iDst, oDst;
   logic [15:0] iA, iB, oResult, oRem;
   logic        oWriteEnable, oBranch, oZero, oCarry, oOverflow, oDivZero;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   alu_exec_unit #(.DATA_W(16), .ADDR_W(8)) dut (
      .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady), .iOp(iOp),
      .iDst(iDst), .iA(iA), .iB(iB), .oValid(oValid), .iReady(iReady),
      .oResult(oResult), .oRem(oRem), .oDst(oDst), .oWriteEnable(oWriteEnable),
      .oBranch(oBranch), .oZero(oZero), .oCarry(oCarry), .oOverflow(oOverflow),
      .oDivZero(oDivZero), .dbg_state(dbg_state)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge Clock);
      #1;
   endtask

   // Offers one op, checks it is takeable, and returns one sample after the accept edge.
   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] dst);
      iOp = op; iA = a; iB = b; iDst = dst; iValid = 1'b1;
      chk("ready_before_accept", oReady, 1);
      step;
      iValid = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [15:0] res, input logic [15:0] rem,
                            input logic [7:0] dst, input logic we, input logic br,
                            input logic z, input logic c, input logic v, input logic dz);
      chk({tag, "_valid"},  oValid, 1);
      chk({tag, "_result"}, oResult, res);
      chk({tag, "_rem"},    oRem, rem);
      chk({tag, "_dst"},    oDst, dst);
      chk({tag, "_flags"},  {oWriteEnable, oBranch, oZero, oCarry, oOverflow, oDivZero},
                            {we, br, z, c, v, dz});
   endtask

   task automatic run_single(input string tag, input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [7:0] dst,
                             input logic [15:0] res, input logic we, input logic br,
                             input logic c, input logic v);
      iReady = 1'b1;
      issue(op, a, b, dst);
      check_out(tag, res, 16'h0000, dst, we, br, (res == 16'h0000), c, v, 1'b0);
      step;
      chk({tag, "_retired"}, oValid, 0);
   endtask

   // Waits for oValid after an iterative op while a junk op is offered during BUSY.
   task automatic run_iter(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [7:0] dst);
      int   lat;
      logic ready_seen;
      iReady = 1'b0;
      issue(op, a, b, dst);
      iValid = 1'b1; iOp = OP_ADD; iA = 16'h0001; iB = 16'h0001; iDst = 8'h99;
      lat = 1;
      ready_seen = 1'b0;
      while (!oValid && lat < 40) begin
         ready_seen |= oReady;
         step;
         lat++;
      end
      iValid = 1'b0;
      chk({tag, "_latency"}, lat, 17);
      chk({tag, "_ready_in_busy"}, ready_seen, 0);
   endtask

   task automatic retire_iter(input string tag);
      iReady = 1'b1;
      step;
      chk({tag, "_retired"}, oValid, 0);
   endtask

   initial begin
      int   valid_seen;
      Reset = 1'b1; iValid = 1'b0; iReady = 1'b1;
      iOp = OP_NOP; iA = '0; iB = '0; iDst = '0;
      repeat (3) step;
      chk("rst_valid", oValid, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      chk("rst_data", {oResult, oRem, oDst}, 0);
      chk("rst_flags", {oWriteEnable, oBranch, oZero, oCarry, oOverflow, oDivZero}, 0);
      Reset = 1'b0;
      step;
      chk("rst_ready", oReady, 1);

      run_single("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 8'h11, 16'h0000, 1, 0, 1, 0);
      run_single("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 8'h12, 16'h8000, 1, 0, 0, 1);
      run_single("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 8'h13, 16'h7FFF, 1, 0, 0, 1);
      run_single("sub_brw",  OP_SUB, 16'h0003, 16'h0005, 8'h14, 16'hFFFE, 1, 0, 1, 0);
      run_single("and",      OP_AND, 16'hF0F0, 16'h3C3C, 8'h15, 16'h3030, 1, 0, 0, 0);
      run_single("or",       OP_OR,  16'hF0F0, 16'h3C3C, 8'h16, 16'hFCFC, 1, 0, 0, 0);
      run_single("xor",      OP_XOR, 16'hF0F0, 16'h3C3C, 8'h17, 16'hCCCC, 1, 0, 0, 0);
      run_single("shl_wrap", OP_SHL, 16'h0003, 16'h0014, 8'h18, 16'h0030, 1, 0, 0, 0);
      run_single("shr",      OP_SHR, 16'h8000, 16'h000F, 8'h19, 16'h0001, 1, 0, 0, 0);
      run_single("slt_t",    OP_SLT, 16'hFFFF, 16'h0001, 8'h1A, 16'h0001, 1, 0, 0, 0);
      run_single("slt_f",    OP_SLT, 16'h0001, 16'hFFFF, 8'h1B, 16'h0000, 1, 0, 0, 0);
      run_single("nop",      OP_NOP, 16'h1234, 16'h5678, 8'h1C, 16'h0000, 0, 0, 0, 0);
      run_single("undef",    4'hF,   16'h1234, 16'h5678, 8'h1D, 16'h0000, 0, 0, 0, 0);
      run_single("ble_gt",   OP_BLE, 16'h0006, 16'h0005, 8'h1E, 16'h0000, 0, 0, 0, 0);
      run_single("ble_lt",   OP_BLE, 16'h0004, 16'h0005, 8'h1F, 16'h0000, 0, 1, 0, 0);

      run_iter("mul_hi", OP_MUL, 16'h0100, 16'h0100, 8'h22);
      check_out("mul_hi", 16'h0000, 16'h0000, 8'h22, 1, 0, 1, 1, 0, 0);
      retire_iter("mul_hi");
      run_iter("mul_lo", OP_MUL, 16'h0123, 16'h0045, 8'h23);
      check_out("mul_lo", 16'h4E6F, 16'h0000, 8'h23, 1, 0, 0, 0, 0, 0);
      retire_iter("mul_lo");
      run_iter("mul_max", OP_MUL, 16'hFFFF, 16'hFFFF, 8'h24);
      check_out("mul_max", 16'h0001, 16'h0000, 8'h24, 1, 0, 0, 1, 0, 0);
      retire_iter("mul_max");
      run_iter("div_zero", OP_DIV, 16'd100, 16'd0, 8'h25);
      check_out("div_zero", 16'hFFFF, 16'd100, 8'h25, 1, 0, 0, 0, 0, 1);
      retire_iter("div_zero");
      run_iter("div_7", OP_DIV, 16'd100, 16'd7, 8'h26);
      check_out("div_7", 16'd14, 16'd2, 8'h26, 1, 0, 0, 0, 0, 0);
      retire_iter("div_7");
      run_iter("div_small", OP_DIV, 16'd7, 16'd100, 8'h27);
      check_out("div_small", 16'd0, 16'd7, 8'h27, 1, 0, 1, 0, 0, 0);
      retire_iter("div_small");

      // BLE held by consumer stall, then back-to-back accept when iReady rises.
      iReady = 1'b0;
      issue(OP_BLE, 16'h0005, 16'h0005, 8'h33);
      check_out("ble_eq", 16'h0000, 16'h0000, 8'h33, 0, 1, 1, 0, 0, 0);
      iValid = 1'b1; iOp = OP_ADD; iA = 16'h0002; iB = 16'h0003; iDst = 8'h44;
      for (int i = 0; i < 4; i++) begin
         step;
         chk("ble_hold", {oValid, oReady, oBranch, oWriteEnable, oDst, oResult},
             {1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 16'h0000});
      end
      iReady = 1'b1;
      #1;
      chk("ble_ready_rise", oReady, 1);
      step;
      iValid = 1'b0;
      check_out("b2b_add", 16'h0005, 16'h0000, 8'h44, 1, 0, 0, 0, 0, 0);
      step;
      chk("b2b_retired", oValid, 0);

      // Reset in the middle of a DIV must drop it without a stale result.
      run_single("pre_rst", OP_ADD, 16'h0010, 16'h0020, 8'h5A, 16'h0030, 1, 0, 0, 0);
      issue(OP_DIV, 16'd1000, 16'd3, 8'h55);
      repeat (7) step;
      chk("abort_busy", dbg_state, ST_BUSY);
      Reset = 1'b1;
      #1;
      chk("abort_in_reset", {oValid, oReady}, 2'b01);
      step;
      Reset = 1'b0;
      valid_seen = 0;
      for (int i = 0; i < 25; i++) begin
         step;
         if (oValid) valid_seen++;
      end
      chk("abort_no_valid", valid_seen, 0);
      chk("abort_ready", oReady, 1);
      chk("abort_cleared", {oResult, oDst, oWriteEnable}, 0);
      run_iter("div_after", OP_DIV, 16'd1000, 16'd3, 8'h56);
      check_out("div_after", 16'd333, 16'd1, 8'h56, 1, 0, 0, 0, 0, 0);
      retire_iter("div_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
